// File: rtl/decode_format_mux_q.sv
`default_nettype none
// ============================================================================
// Module   : decode_format_mux_q
// Purpose  : Second-stage decode multiplexer with an output queue.
//            The lowest-index valid format-decoder channel wins each cycle.
//            The winner is tagged with its format code, instruction address
//            and opcode, then pushed into a DEPTH-entry FIFO. The FIFO drains
//            to the issue stage over a valid/ready handshake. ready_o gives
//            back-pressure to decode stage 1.
// Ports    : clock_i, reset_i (sync, active-high), flush_i
//            instructionAddress_i, opcode_i, chValid_i, chPayload_i,
//            chFormat_i                        -- upstream offer
//            ready_o                           -- queue not full
//            valid_o, ready_i, payload_o, format_o,
//            instructionAddress_o, opcode_o    -- head entry / issue handshake
//            count_o                           -- occupied entries
//            conflict_o                        -- sticky multi-valid flag
// Options  : DECODE_MUX_CONFLICT_EN -- when defined, conflict_o is set by a
//            push that has more than one channel valid. When undefined,
//            conflict_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module decode_format_mux_q #(
  parameter int NUM_CH    = 6,
  parameter int PAYLOAD_W = 48,
  parameter int FMT_W     = 5,
  parameter int ADDR_W    = 64,
  parameter int OPC_W     = 6,
  parameter int DEPTH     = 4
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic [ADDR_W-1:0]           instructionAddress_i,
  input  logic [OPC_W-1:0]            opcode_i,
  input  logic [NUM_CH-1:0]           chValid_i,
  input  logic [NUM_CH*PAYLOAD_W-1:0] chPayload_i,
  input  logic [NUM_CH*FMT_W-1:0]     chFormat_i,
  output logic                        ready_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [PAYLOAD_W-1:0]        payload_o,
  output logic [FMT_W-1:0]            format_o,
  output logic [ADDR_W-1:0]           instructionAddress_o,
  output logic [OPC_W-1:0]            opcode_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic                        conflict_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = PAYLOAD_W + FMT_W + ADDR_W + OPC_W;

  logic [PAYLOAD_W-1:0] w_sel_payload;
  logic [FMT_W-1:0]     w_sel_format;
  logic [ENTRY_W-1:0]   w_wr_entry;
  logic [ENTRY_W-1:0]   w_head;
  logic                 w_push;
  logic                 w_pop;

  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  // Fixed-priority select. The loop scans downward, so the lowest valid
  // index is written last and wins.
  always_comb begin
    w_sel_payload = '0;
    w_sel_format  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (chValid_i[k]) begin
        w_sel_payload = chPayload_i[k*PAYLOAD_W +: PAYLOAD_W];
        w_sel_format  = chFormat_i[k*FMT_W +: FMT_W];
      end
    end
  end

  assign w_wr_entry = {w_sel_payload, w_sel_format, instructionAddress_i, opcode_i};

  // ready_o and valid_o depend only on the registered count. This keeps
  // ready_i off any path into ready_o.
  assign ready_o = (r_count != CNT_W'(DEPTH));
  assign valid_o = (r_count != '0);
  assign count_o = r_count;

  assign w_push = (|chValid_i) & ready_o & ~flush_i;
  assign w_pop  = valid_o & ready_i & ~flush_i;

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset so that the head fields read as zero after
  // reset. A flush leaves the contents in place; they are unreachable
  // because valid_o is low.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  assign w_head               = r_mem[r_rd_ptr];
  assign payload_o            = w_head[ENTRY_W-1 -: PAYLOAD_W];
  assign format_o             = w_head[ADDR_W+OPC_W +: FMT_W];
  assign instructionAddress_o = w_head[OPC_W +: ADDR_W];
  assign opcode_o             = w_head[0 +: OPC_W];

`ifdef DECODE_MUX_CONFLICT_EN
  logic r_conflict;

  // Clearing the lowest set bit leaves a nonzero value only when two or more
  // channels are valid. Only reset clears the flag; flush does not.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_conflict <= 1'b0;
    end else if (w_push && ((chValid_i & (chValid_i - NUM_CH'(1))) != '0)) begin
      r_conflict <= 1'b1;
    end
  end

  assign conflict_o = r_conflict;
`else
  assign conflict_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_format_mux_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_format_mux_q
// Purpose  : Scoreboard testbench for decode_format_mux_q.
//            The queue model works in transactions: a list of accepted
//            instructions. Each falling edge compares the DUT against that
//            list, then applies the push, pop, flush or reset that the next
//            rising edge will perform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_format_mux_q;

  localparam int NUM_CH = 6;
  localparam int PW     = 48;
  localparam int FW     = 5;
  localparam int AW     = 64;
  localparam int OW     = 6;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PW-1:0] p;
    logic [FW-1:0] f;
    logic [AW-1:0] a;
    logic [OW-1:0] o;
  } ent_t;

  logic                   clock_i = 1'b0;
  logic                   reset_i = 1'b1;
  logic                   flush_i = 1'b0;
  logic [AW-1:0]          instructionAddress_i = '0;
  logic [OW-1:0]          opcode_i = '0;
  logic [NUM_CH-1:0]      chValid_i = '0;
  logic [NUM_CH*PW-1:0]   chPayload_i = '0;
  logic [NUM_CH*FW-1:0]   chFormat_i = '0;
  logic                   ready_o;
  logic                   valid_o;
  logic                   ready_i = 1'b0;
  logic [PW-1:0]          payload_o;
  logic [FW-1:0]          format_o;
  logic [AW-1:0]          instructionAddress_o;
  logic [OW-1:0]          opcode_o;
  logic [CW-1:0]          count_o;
  logic                   conflict_o;

  decode_format_mux_q #(
    .NUM_CH(NUM_CH), .PAYLOAD_W(PW), .FMT_W(FW), .ADDR_W(AW),
    .OPC_W(OW), .DEPTH(DEPTH)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
    .instructionAddress_i(instructionAddress_i), .opcode_i(opcode_i),
    .chValid_i(chValid_i), .chPayload_i(chPayload_i), .chFormat_i(chFormat_i),
    .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .payload_o(payload_o), .format_o(format_o),
    .instructionAddress_o(instructionAddress_o), .opcode_o(opcode_o),
    .count_o(count_o), .conflict_o(conflict_o)
  );

  always #5 clock_i = ~clock_i;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  bit   started   = 0;
  bit   zero_head = 0;
  bit   m_conflict = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The winner is the lowest-index valid channel. Address and opcode come
  // from the shared instruction inputs.
  function automatic ent_t winner();
    ent_t e;
    e = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chValid_i[k]) begin
        e.p = chPayload_i[k*PW +: PW];
        e.f = chFormat_i[k*FW +: FW];
        break;
      end
    end
    e.a = instructionAddress_i;
    e.o = opcode_i;
    return e;
  endfunction

  // Monitor and scoreboard.
  always @(negedge clock_i) begin
    bit push, pop;
    if (started) begin
      chk("count", 64'(count_o), 64'(q.size()));
      chk("valid", 64'(valid_o), 64'(q.size() != 0));
      chk("ready", 64'(ready_o), 64'(q.size() != DEPTH));
      chk("conflict", 64'(conflict_o), 64'(m_conflict));
      if (q.size() != 0) begin
        chk("head_payload", 64'(payload_o), 64'(q[0].p));
        chk("head_format", 64'(format_o), 64'(q[0].f));
        chk("head_addr", 64'(instructionAddress_o), 64'(q[0].a));
        chk("head_opcode", 64'(opcode_o), 64'(q[0].o));
      end else if (zero_head) begin
        chk("reset_head_payload", 64'(payload_o), 64'd0);
        chk("reset_head_addr", 64'(instructionAddress_o), 64'd0);
      end
    end
    if (reset_i) begin
      q.delete();
      m_conflict = 0;
      started    = 1;
      zero_head  = 1;
    end else if (started) begin
      if (flush_i) begin
        q.delete();
      end else begin
        push = (chValid_i != 0) && (q.size() != DEPTH);
        pop  = (q.size() != 0) && ready_i;
`ifdef DECODE_MUX_CONFLICT_EN
        if (push && $countones(chValid_i) > 1) m_conflict = 1;
`endif
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back(winner());
          zero_head = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic rand_channels();
    for (int k = 0; k < NUM_CH; k++) begin
      chPayload_i[k*PW +: PW] = {$urandom, $urandom};
      chFormat_i[k*FW +: FW]  = FW'($urandom);
    end
    instructionAddress_i = {$urandom, $urandom};
    opcode_i             = OW'($urandom);
  endtask

  // Offers v and holds it until ready_o allows the next edge to accept it.
  task automatic offer(input logic [NUM_CH-1:0] v);
    int n;
    n = 0;
    chValid_i = v;
    while (!ready_o && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL offer_timeout: got ready_o=0 expected 1 at %0t", $time);
    end
    step();
    chValid_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
    step();

    // Single push from channel 2, drained straight away.
    ready_i = 1'b1;
    rand_channels();
    chPayload_i[2*PW +: PW] = 48'hA5;
    chFormat_i[2*FW +: FW]  = 5'd3;
    instructionAddress_i    = 64'h100;
    offer(6'b000100);
    step(); step();

    // Two channels valid: channel 1 wins. Flush then leaves the flag alone.
    rand_channels();
    offer(6'b010010);
    step();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    step();

    // Fill to full with ready_i low. The fifth offer is held until a pop.
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_channels();
      offer(6'(1 << (i % NUM_CH)));
    end
    rand_channels();
    chValid_i = 6'b100000;
    step(); step(); step();
    ready_i = 1'b1;
    offer(6'b100000);
    repeat (6) step();

    // Push and pop on every cycle across pointer wrap, starting from two.
    ready_i = 1'b0;
    rand_channels(); offer(6'b000001);
    rand_channels(); offer(6'b001000);
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_channels();
      chValid_i = 6'($urandom_range(1, 63));
      step();
    end
    chValid_i = '0;
    repeat (3) step();

    // Flush at count 3 while pushing.
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_channels(); offer(6'b000010);
    end
    rand_channels();
    chValid_i = 6'b000001;
    flush_i   = 1'b1;
    step();
    flush_i   = 1'b0;
    chValid_i = '0;
    step();

    // Reset in the middle of a drain with count 2.
    for (int i = 0; i < 2; i++) begin
      rand_channels(); offer(6'b000100);
    end
    ready_i = 1'b1;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_channels();
      chValid_i = ($urandom_range(0, 3) == 0) ? '0 : 6'($urandom);
      ready_i   = 1'($urandom_range(0, 2) != 0);
      flush_i   = ($urandom_range(0, 29) == 0);
      reset_i   = ($urandom_range(0, 99) == 0);
      step();
    end
    chValid_i = '0; flush_i = 1'b0; reset_i = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_format_mux_q.md
# decode_format_mux_q

Parametrised second-stage decode multiplexer with an output queue. It takes NUM_CH parallel format-decoder channels, each a valid plus a packed payload, and selects one per cycle by fixed priority, lowest index first. It tags the selection with its format code and instruction address, then pushes it into a DEPTH-entry FIFO. The FIFO drains to the issue stage over a valid/ready handshake and drives back-pressure into decode stage 1.

## Interface
Parameters:
- NUM_CH, 6: number of format-decoder channels.
- PAYLOAD_W, 48: per-channel packed payload width (regs, enables, imm, bits, FU code).
- FMT_W, 5: instruction-format code width.
- ADDR_W, 64: instruction address width.
- OPC_W, 6: primary opcode width.
- DEPTH, 4: FIFO entries; a power of two, at least 2.

Ports:
- clock_i, in, 1: sole clock, rising edge.
- reset_i, in, 1: synchronous, active-high reset.
- flush_i, in, 1: synchronous discard of all queued entries.
- instructionAddress_i, in, ADDR_W: address of the instruction being offered.
- opcode_i, in, OPC_W: primary opcode of the instruction being offered.
- chValid_i, in, NUM_CH: per-channel valid; bit k belongs to channel k.
- chPayload_i, in, NUM_CH*PAYLOAD_W: channel k occupies bits [k*PAYLOAD_W +: PAYLOAD_W].
- chFormat_i, in, NUM_CH*FMT_W: channel k format code, packed the same way.
- ready_o, out, 1: queue can accept an instruction this cycle.
- valid_o, out, 1: head entry is valid.
- ready_i, in, 1: issue stage accepts the head entry.
- payload_o, out, PAYLOAD_W: head entry payload.
- format_o, out, FMT_W: head entry format code.
- instructionAddress_o, out, ADDR_W: head entry address.
- opcode_o, out, OPC_W: head entry opcode.
- count_o, out, $clog2(DEPTH+1): number of occupied entries.
- conflict_o, out, 1: sticky multi-valid error flag (see Configuration).

## Operation
- Select: the winner is the lowest k with chValid_i[k]=1; this logic is combinational.
- Push: push = (|chValid_i) & ready_o & !flush_i. On a push, {payload, format, address, opcode} of the winner is written at wrPtr and wrPtr increments.
- Pop: pop = valid_o & ready_i & !flush_i. On a pop, rdPtr increments.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- count_o: +1 on push only, -1 on pop only, unchanged on push and pop together.
- ready_o = (count_o != DEPTH). It is derived from registered count only; there is no combinational path from ready_i.
- valid_o = (count_o != 0). The head fields are read from the storage at rdPtr.
- Flush: the next cycle has count=0 and both pointers=0. Any push or pop in the flush cycle is ignored.
- Reset: count, both pointers, valid_o and conflict_o are 0 next cycle. Storage contents are don't-care, but the head fields read as 0 after reset (storage is cleared).
- Reset has priority over flush; flush has priority over push and pop.
- A channel with chValid_i=0 is never written, whatever its payload holds.

## Timing
- Latency: an instruction pushed at edge N appears on valid_o/payload_o after edge N; there is no fall-through.
- Sustained throughput is one instruction per cycle while ready_i=1.
- Full (count=DEPTH): ready_o=0 and offered inputs are not captured. A pop in that cycle makes ready_o=1 the following cycle; there is no same-cycle refill.
- Empty: valid_o=0 and ready_i is ignored.
- When count=1 and push and pop coincide, valid_o stays 1 and the new entry becomes head next cycle.
- Upstream must hold its inputs while ready_o=0.

## Configuration
- DECODE_MUX_CONFLICT_EN defined: conflict_o is set when a cycle has push=1 and more than one bit of chValid_i set. It holds until reset_i; flush_i does not clear it.
- DECODE_MUX_CONFLICT_EN undefined: conflict_o is tied to 0 and the detector logic is absent. Select and push behaviour is identical in both builds.

## Test plan
- Reset, then push channel 2 with payload 0xA5, format 3, address 0x100, ready_i=1: valid_o=1 the next cycle with payload 0xA5, format 3, address 0x100; popped the cycle after, count returns to 0.
- chValid_i=0b010010 (channels 1 and 4): channel 1 payload is queued. With the macro defined conflict_o=1 and stays 1 after flush; without it conflict_o=0.
- ready_i=0 with 5 back-to-back pushes and DEPTH=4: count_o=4, ready_o=0, 5th held. Raise ready_i: entries drain in order, 5th accepted the cycle after the first pop.
- Push and pop together on every cycle for 10 cycles across pointer wrap: count_o is constant, order preserved, no loss.
- flush_i with count=3 while pushing: count_o=0, valid_o=0 next cycle, and the pushed instruction is dropped.
- reset_i asserted mid-drain with count=2: all outputs 0 next cycle and ready_o=1.
